// File: rtl/ps2_key_state_tracker_pkg.sv
// Shared constants for the PS/2 key-state tracker: key indices, Set-2 scancodes,
// FSM state types and the scancode-to-key lookup.
package ps2_key_state_tracker_pkg;

  localparam int NUMBEROFKEYBOARDINPUTS = 16;
  localparam int KEY_INDEX_W = 5;

  // Note keys follow a piano layout on the home and upper letter rows
  localparam logic [4:0] keyNoteC     = 5'd0;
  localparam logic [4:0] keyNoteCs    = 5'd1;
  localparam logic [4:0] keyNoteD     = 5'd2;
  localparam logic [4:0] keyNoteDs    = 5'd3;
  localparam logic [4:0] keyNoteE     = 5'd4;
  localparam logic [4:0] keyNoteF     = 5'd5;
  localparam logic [4:0] keyNoteFs    = 5'd6;
  localparam logic [4:0] keyNoteG     = 5'd7;
  localparam logic [4:0] keyNoteGs    = 5'd8;
  localparam logic [4:0] keyNoteA     = 5'd9;
  localparam logic [4:0] keyNoteAs    = 5'd10;
  localparam logic [4:0] keyNoteB     = 5'd11;
  localparam logic [4:0] keyNoteC2    = 5'd12;
  localparam logic [4:0] keySpacebar  = 5'd13;
  localparam logic [4:0] keyR         = 5'd14;
  localparam logic [4:0] keyBackslash = 5'd15;

  localparam logic [7:0] SC_SPACE     = 8'h29;
  localparam logic [7:0] SC_R         = 8'h2D;
  localparam logic [7:0] SC_BACKSLASH = 8'h5D;
  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_BAT_OK  = 8'hAA;
  localparam logic [7:0] BYTE_ACK     = 8'hFA;
  localparam logic [7:0] BYTE_RESEND  = 8'hFE;
  localparam logic [7:0] BYTE_OVF_LO  = 8'h00;
  localparam logic [7:0] BYTE_OVF_HI  = 8'hFF;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_WAIT, DEC_GOT_E0, DEC_GOT_F0, DEC_GOT_E0F0} dec_state_t;

  typedef struct packed {
    logic                   valid;
    logic [KEY_INDEX_W-1:0] index;
  } key_lookup_t;

  // No extended (E0-prefixed) key is tracked, so those codes always miss
  function automatic key_lookup_t lookup_key(input logic ext, input logic [7:0] code);
    key_lookup_t r;
    r.valid = 1'b1;
    r.index = '0;
    if (ext) begin
      r.valid = 1'b0;
    end else begin
      case (code)
        8'h1C:        r.index = keyNoteC;
        8'h1D:        r.index = keyNoteCs;
        8'h1B:        r.index = keyNoteD;
        8'h24:        r.index = keyNoteDs;
        8'h23:        r.index = keyNoteE;
        8'h2B:        r.index = keyNoteF;
        8'h2C:        r.index = keyNoteFs;
        8'h34:        r.index = keyNoteG;
        8'h35:        r.index = keyNoteGs;
        8'h33:        r.index = keyNoteA;
        8'h3C:        r.index = keyNoteAs;
        8'h3B:        r.index = keyNoteB;
        8'h42:        r.index = keyNoteC2;
        SC_SPACE:     r.index = keySpacebar;
        SC_R:         r.index = keyR;
        SC_BACKSLASH: r.index = keyBackslash;
        default:      r.valid = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_state_tracker_byte_receiver.sv
// PS/2 frame receiver: synchronizes the raw lines, samples on falling ps2Clk
// edges and delivers checked bytes or a frame-error pulse.
module ps2_byte_receiver
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       frameError
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          fall;
  logic          bit_in;
  rx_state_t     state;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic [CW-1:0] idle_cnt;

  // Lines idle high, so the synchronizers reset to 1 to avoid a phantom edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2Clk};
      data_sync <= {data_sync[0], ps2Data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      idle_cnt   <= '0;
      byteValid  <= 1'b0;
      byteData   <= '0;
      frameError <= 1'b0;
    end else begin
      byteValid  <= 1'b0;
      frameError <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!bit_in) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shift_reg <= {bit_in, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_bit <= bit_in;
            state      <= RX_STOP;
          end
          RX_STOP: begin
            if (bit_in && (^{shift_reg, parity_bit})) begin
              byteValid <= 1'b1;
              byteData  <= shift_reg;
            end else begin
              frameError <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        if (idle_cnt == IDLE_LIMIT) begin
          state      <= RX_IDLE;
          frameError <= 1'b1;
          idle_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + CW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_state_tracker.sv
// Top level: decodes Set-2 make/break sequences from the byte receiver into
// the held-key vector and a one-cycle event strobe per key transition.
module ps2_key_state_tracker
  import ps2_key_state_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              ps2Clk,
  input  logic                              ps2Data,
  output logic [NUMBEROFKEYBOARDINPUTS-1:0] inputStateStorage,
  output logic                              keyEvent,
  output logic [KEY_INDEX_W-1:0]            keyEventIndex,
  output logic                              keyEventPressed,
  output logic                              frameError
);

  localparam int N = NUMBEROFKEYBOARDINPUTS;

  logic        byte_valid;
  logic [7:0]  byte_data;
  dec_state_t  dec_state;
  logic        code_ext;
  logic        code_brk;
  logic        is_ignored;
  logic        is_overflow;
  key_lookup_t hit;
  logic [N-1:0] key_mask;
  logic        key_held;

  ps2_byte_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_receiver (
    .clk       (clk),
    .rst       (resetn),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .byteValid (byte_valid),
    .byteData  (byte_data),
    .frameError(frameError)
  );

  always_comb begin
    code_ext    = (dec_state == DEC_GOT_E0) || (dec_state == DEC_GOT_E0F0);
    code_brk    = (dec_state == DEC_GOT_F0) || (dec_state == DEC_GOT_E0F0);
    is_ignored  = (byte_data == BYTE_BAT_OK) || (byte_data == BYTE_ACK) ||
                  (byte_data == BYTE_RESEND);
    is_overflow = (byte_data == BYTE_OVF_LO) || (byte_data == BYTE_OVF_HI);
    hit         = lookup_key(code_ext, byte_data);
    key_mask    = {{(N-1){1'b0}}, 1'b1} << hit.index;
    key_held    = |(inputStateStorage & key_mask);
  end

  // A make on a released key or a break on a held key toggles that bit;
  // typematic repeats and stray breaks match neither case and are dropped
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      dec_state         <= DEC_WAIT;
      inputStateStorage <= '0;
      keyEvent          <= 1'b0;
      keyEventIndex     <= '0;
      keyEventPressed   <= 1'b0;
    end else begin
      keyEvent <= 1'b0;
      if (frameError) begin
        dec_state <= DEC_WAIT;
      end else if (byte_valid && !is_ignored) begin
        if (is_overflow) begin
          inputStateStorage <= '0;
          dec_state         <= DEC_WAIT;
        end else if (dec_state == DEC_WAIT && byte_data == PREFIX_EXT) begin
          dec_state <= DEC_GOT_E0;
        end else if (dec_state == DEC_WAIT && byte_data == PREFIX_BREAK) begin
          dec_state <= DEC_GOT_F0;
        end else if (dec_state == DEC_GOT_E0 && byte_data == PREFIX_BREAK) begin
          dec_state <= DEC_GOT_E0F0;
        end else begin
          dec_state <= DEC_WAIT;
          if (hit.valid && (code_brk == key_held)) begin
            inputStateStorage <= inputStateStorage ^ key_mask;
            keyEvent          <= 1'b1;
            keyEventIndex     <= hit.index;
            keyEventPressed   <= ~code_brk;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
// Scoreboard bench: a byte-level keyboard model predicts key events and the
// held-key vector; a monitor pops expected events as the DUT strobes them.
module tb_ps2_key_state_tracker;
  import ps2_key_state_tracker_pkg::*;

  localparam int N          = NUMBEROFKEYBOARDINPUTS;
  localparam int TB_TIMEOUT = 3000;
  localparam int HALF       = 10;

  typedef struct {
    int index;
    bit pressed;
  } ev_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ps2Clk;
  logic         ps2Data;
  logic [N-1:0] inputStateStorage;
  logic         keyEvent;
  logic [4:0]   keyEventIndex;
  logic         keyEventPressed;
  logic         frameError;

  ev_t          exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           exp_errors = 0;
  int           seen_errors = 0;
  logic [N-1:0] model_vec = '0;
  bit           ext_pend = 1'b0;
  bit           brk_pend = 1'b0;
  int           key_map[int];
  logic [7:0]   mapped_codes[16];

  always #5 clk = ~clk;

  ps2_key_state_tracker #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .ps2Clk           (ps2Clk),
    .ps2Data          (ps2Data),
    .inputStateStorage(inputStateStorage),
    .keyEvent         (keyEvent),
    .keyEventIndex    (keyEventIndex),
    .keyEventPressed  (keyEventPressed),
    .frameError       (frameError)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Keyboard-protocol model: prefixes accumulate, any other byte is a key code
  function automatic void model_byte(input logic [7:0] b);
    int   key;
    ev_t  ev;
    if (b == 8'hAA || b == 8'hFA || b == 8'hFE) return;
    if (b == 8'h00 || b == 8'hFF) begin
      model_vec = '0;
      ext_pend  = 1'b0;
      brk_pend  = 1'b0;
      return;
    end
    if (b == 8'hE0 && !ext_pend && !brk_pend) begin
      ext_pend = 1'b1;
      return;
    end
    if (b == 8'hF0 && !brk_pend) begin
      brk_pend = 1'b1;
      return;
    end
    key = {23'd0, ext_pend, b};
    if (key_map.exists(key)) begin
      if (!brk_pend && model_vec[key_map[key]] == 1'b0) begin
        model_vec[key_map[key]] = 1'b1;
        ev.index = key_map[key]; ev.pressed = 1'b1;
        exp_q.push_back(ev);
      end else if (brk_pend && model_vec[key_map[key]] == 1'b1) begin
        model_vec[key_map[key]] = 1'b0;
        ev.index = key_map[key]; ev.pressed = 1'b0;
        exp_q.push_back(ev);
      end
    end
    ext_pend = 1'b0;
    brk_pend = 1'b0;
  endfunction

  task automatic ps2_bit(input logic v);
    @(negedge clk) ps2Data = v;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_parity);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_parity);
    ps2_bit(1'b1);
    ps2Data = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit bad_parity);
    if (bad_parity) begin
      exp_errors++;
      ext_pend = 1'b0;
      brk_pend = 1'b0;
    end else begin
      model_byte(b);
    end
    send_frame(b, bad_parity);
    repeat (12) @(negedge clk);
    checkOutput($sformatf("key vector after 0x%02h", b), 32'(inputStateStorage), 32'(model_vec));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " inputStateStorage"}, 32'(inputStateStorage), 32'd0);
    checkOutput({tag, " keyEvent"}, 32'(keyEvent), 32'd0);
    checkOutput({tag, " keyEventIndex"}, 32'(keyEventIndex), 32'd0);
    checkOutput({tag, " keyEventPressed"}, 32'(keyEventPressed), 32'd0);
    checkOutput({tag, " frameError"}, 32'(frameError), 32'd0);
  endtask

  // Monitor: every strobe must match the oldest predicted event
  always @(negedge clk) begin
    if (resetn === 1'b0) begin
      if (keyEvent || frameError)
        checkOutput("keyEvent/frameError overlap", 32'(keyEvent & frameError), 32'd0);
      if (frameError) seen_errors++;
      if (keyEvent) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected keyEvent: got index %0d pressed %0b, expected no event",
                   keyEventIndex, keyEventPressed);
        end else begin
          ev_t ev;
          ev = exp_q.pop_front();
          checkOutput("keyEventIndex", 32'(keyEventIndex), 32'(ev.index));
          checkOutput("keyEventPressed", 32'(keyEventPressed), 32'(ev.pressed));
        end
      end
    end
  end

  initial begin
    int         r;
    logic [7:0] b;
    logic [7:0] unmapped[4];
    logic [7:0] specials[3];

    mapped_codes = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34,
                     8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42, 8'h29, 8'h2D, 8'h5D};
    for (int i = 0; i < 16; i++) key_map[{23'd0, 1'b0, mapped_codes[i]}] = i;
    unmapped = '{8'h15, 8'h76, 8'h5A, 8'h66};
    specials = '{8'hAA, 8'hFA, 8'hFE};

    resetn  = 1'b1;
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (5) @(negedge clk);
    checkResetOutputs("reset");
    resetn = 1'b0;
    repeat (10) @(negedge clk);

    // Space make, break (F0 alone silent), typematic repeat
    applyStimulus(8'h29, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h29, 1'b0);
    applyStimulus(8'h29, 1'b0);
    applyStimulus(8'h29, 1'b0);
    applyStimulus(8'h29, 1'b0);

    // Bad parity on R, then a good R
    applyStimulus(8'h2D, 1'b1);
    checkOutput("frameError count after parity", seen_errors, exp_errors);
    applyStimulus(8'h2D, 1'b0);

    // Overflow with R and Space held
    applyStimulus(8'h00, 1'b0);

    // Extended prefix must not alias a plain key
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'h29, 1'b0);

    // Timeout on a partial frame, then Backslash
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2Data = 1'b1;
    exp_errors++;
    ext_pend = 1'b0;
    brk_pend = 1'b0;
    repeat (TB_TIMEOUT + 600) @(negedge clk);
    checkOutput("frameError count after timeout", seen_errors, exp_errors);
    applyStimulus(8'h5D, 1'b0);

    // Randomized byte stream
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)      applyStimulus(mapped_codes[$urandom_range(0, 15)], 1'b0);
      else if (r < 55) applyStimulus(8'hF0, 1'b0);
      else if (r < 62) applyStimulus(8'hE0, 1'b0);
      else if (r < 68) applyStimulus(specials[$urandom_range(0, 2)], 1'b0);
      else if (r < 74) applyStimulus(unmapped[$urandom_range(0, 3)], 1'b0);
      else if (r < 76) applyStimulus(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, 1'b0);
      else if (r < 82) begin
        b = 8'($urandom_range(0, 255));
        applyStimulus(b, 1'b1);
      end else         applyStimulus(mapped_codes[$urandom_range(0, 15)], 1'b0);
    end
    checkOutput("frameError count after random", seen_errors, exp_errors);

    // Reset in the middle of a frame with a key held
    applyStimulus(8'hF0, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    applyStimulus(8'h1C, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    @(negedge clk) resetn = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("mid-frame reset");
    checkOutput("events pending at reset", exp_q.size(), 0);
    exp_q.delete();
    model_vec = '0;
    ext_pend  = 1'b0;
    brk_pend  = 1'b0;
    ps2Data   = 1'b1;
    resetn    = 1'b0;
    repeat (50) @(negedge clk);
    applyStimulus(8'h29, 1'b0);

    repeat (20) @(negedge clk);
    checkOutput("events left undelivered", exp_q.size(), 0);
    checkOutput("frameError total", seen_errors, exp_errors);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_state_tracker.md
# ps2_key_state_tracker

Producer side of the keyboard-state bus: receives raw PS/2 frames from the keyboard, decodes Set-2 make/break scancodes, and maintains the `inputStateStorage` vector that the master FSM and playback logic consume. One bit per tracked key, 1 while the key is held. It also emits a one-cycle event strobe per key transition for the recorder.

## Interface
- `NUMBEROFKEYBOARDINPUTS` (macro), no default here; width of the key-state vector, taken from `DefineMacros.vh`.
- `TIMEOUT_CYCLES` parameter, default 50000; a partial frame is abandoned after this many idle `clk` cycles (1 ms at 50 MHz).
- `clk` input, 1 bit: system clock.
- `resetn` input, 1 bit: reset, **asynchronous, active-high**; the name is kept for bus compatibility.
- `ps2Clk` input, 1 bit: raw PS/2 clock, asynchronous to `clk`.
- `ps2Data` input, 1 bit: raw PS/2 data, asynchronous to `clk`.
- `inputStateStorage` output, `NUMBEROFKEYBOARDINPUTS` bits: held-key vector.
- `keyEvent` output, 1 bit: one-cycle pulse on any bit change of `inputStateStorage`.
- `keyEventIndex` output, 5 bits: index of the changed key. Valid with `keyEvent`.
- `keyEventPressed` output, 1 bit: 1 means make, 0 means break. Valid with `keyEvent`.
- `frameError` output, 1 bit: one-cycle pulse when a frame is discarded.

## Operation
- Synchronization
  - `ps2Clk` and `ps2Data` each pass through a 2-FF synchronizer.
  - A falling edge is detected when the registered previous value is 1 and the current synchronized value is 0.
  - Data is sampled only on the detected falling edge.
- Receiver FSM (IDLE, DATA, PARITY, STOP), frame = start 0, 8 data bits LSB first, odd parity, stop 1.
  - IDLE: a sampled 0 goes to DATA. A sampled 1 stays in IDLE with no error.
  - DATA: shifts 8 bits, then goes to PARITY.
  - PARITY: stores the parity bit.
  - STOP: stop=1 with odd parity correct raises `byteValid` for one cycle carrying the byte, then returns to IDLE. Otherwise it pulses `frameError`, discards the byte and returns to IDLE.
  - Timeout: outside IDLE, `TIMEOUT_CYCLES` cycles with no falling edge returns the FSM to IDLE and pulses `frameError`.
- Decoder FSM (WAIT, GOT_E0, GOT_F0, GOT_E0F0), driven by `byteValid`.
  - Transitions: WAIT+E0 → GOT_E0; WAIT+F0 → GOT_F0; GOT_E0+F0 → GOT_E0F0.
  - Any other byte is a code. The pair {extended flag, code} is looked up in the key map, then the FSM returns to WAIT.
  - Mapped make: if the bit is 0, set it and pulse `keyEvent` with pressed=1. If the bit is already 1 (typematic repeat), do nothing.
  - Mapped break: if the bit is 1, clear it and pulse `keyEvent` with pressed=0. If the bit is already 0, do nothing.
  - Unmapped code: no state change and no event.
  - Bytes 0x00 and 0xFF (buffer overflow/error): clear the whole vector, no `keyEvent`, FSM returns to WAIT.
  - Bytes 0xAA, 0xFA and 0xFE are ignored in any state and do not disturb a pending prefix.
  - Any `frameError` forces the decoder back to WAIT, dropping any pending prefix.
- Reset (asserted at any time, including mid-frame):
  - Both FSMs go to IDLE/WAIT and the partial shift register is discarded.
  - `inputStateStorage` = 0; `keyEvent`, `keyEventIndex`, `keyEventPressed` and `frameError` = 0.

## Timing
- Falling-edge detection lags the raw `ps2Clk` fall by 2–3 `clk` cycles (synchronizer plus edge register).
- `byteValid` asserts on the cycle after the stop-bit sample.
- `inputStateStorage` and `keyEvent` update on the `clk` edge following `byteValid`. Latency from the stop-bit falling edge is at most 5 cycles.
- At most one `keyEvent` per received byte. Consecutive bytes are ≥ 60 µs apart, so no back-pressure exists.
- `frameError` and `keyEvent` never assert in the same cycle.

## Structure
- `DefineMacros.vh` holds:
  - `NUMBEROFKEYBOARDINPUTS`.
  - Key index macros: `keySpacebar`, `keyR`, `keyBackslash`, plus the note keys.
  - Scancode macros for each key (Space 0x29, R 0x2D, Backslash 0x5D).
  - Prefix constants 0xE0 and 0xF0.
- Sub-module `ps2_byte_receiver`: synchronizer, edge detect, receiver FSM and timeout counter. Outputs `byteValid`, `byteData` and `frameError`.
- The top level contains the decoder FSM and a combinational scancode-to-index lookup. The lookup returns a valid flag plus a 5-bit index.

## Test plan
- Space make: frame 0x29 → `inputStateStorage[keySpacebar]`=1, and one `keyEvent` with index=`keySpacebar`, pressed=1.
- Space break: frames F0,29 after a make → bit cleared, and one `keyEvent` with pressed=0. The F0 frame alone causes no event.
- Typematic repeat: frames 29,29,29 → bit stays 1, exactly one `keyEvent` total.
- Parity error: 0x2D sent with even parity → `frameError` pulse, keyR stays 0. A following good 0x2D sets keyR.
- Timeout: start plus 4 data bits, then 60000 idle cycles → one `frameError`. A following 0x5D sets `keyBackslash`.
- Overflow and reset:
  - Overflow: hold R and Space, send 0x00 → vector = 0, no `keyEvent`.
  - Reset: assert `resetn` mid-frame → all outputs 0. A complete 0x29 frame after release decodes normally.
